sm3_expnd_arb: RTL and testbench

SM3_EXPND_ARB -- requirements
Module: sm3_expnd_arb

---
 rtl/sm3_expnd_arb.sv | 123 ++++++++++++
 tb/tb_sm3_expnd_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_expnd_arb.sv
// rtl/sm3_expnd_arb.sv - two-requester round-robin arbiter feeding the SM3 expansion core
// Tracks the requester ID of each message in flight so the expansion output can be attributed.
module sm3_expnd_arb #(
  parameter int DW        = 32,
  parameter int IDQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] req0_d_i,
  input  logic          req0_vld_i,
  input  logic          req0_lst_i,
  output logic          req0_rdy_o,
  input  logic [DW-1:0] req1_d_i,
  input  logic          req1_vld_i,
  input  logic          req1_lst_i,
  output logic          req1_rdy_o,
  output logic [DW-1:0] pad_inpt_d_o,
  output logic          pad_inpt_vld_o,
  output logic          pad_inpt_lst_o,
  input  logic          pad_inpt_rdy_i,
  input  logic          expnd_otpt_vld_i,
  input  logic          expnd_otpt_lst_i,
  input  logic          expnd_otpt_ena_i,
  output logic          expnd_otpt_id_o,
  output logic          busy_o
);

  localparam int PW = $clog2(IDQ_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(IDQ_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [IDQ_DEPTH-1:0] idq_q;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [PW:0]          cnt_q;
  logic                 full, empty, push, pop, gnt_id;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign pop   = expnd_otpt_vld_i & expnd_otpt_ena_i & expnd_otpt_lst_i & ~empty;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    push           = 1'b0;
    gnt_id         = 1'b0;
    pad_inpt_d_o   = '0;
    pad_inpt_vld_o = 1'b0;
    pad_inpt_lst_o = 1'b0;
    req0_rdy_o     = 1'b0;
    req1_rdy_o     = 1'b0;
    case (state_q)
      IDLE: begin
        // last_q holds the requester served most recently; the other one wins a tie
        if ((req0_vld_i | req1_vld_i) && !full) begin
          push    = 1'b1;
          gnt_id  = (req0_vld_i && req1_vld_i) ? ~last_q : req1_vld_i;
          state_d = gnt_id ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        pad_inpt_d_o   = req0_d_i;
        pad_inpt_vld_o = req0_vld_i;
        pad_inpt_lst_o = req0_lst_i;
        req0_rdy_o     = pad_inpt_rdy_i;
        if (req0_vld_i && pad_inpt_rdy_i && req0_lst_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        pad_inpt_d_o   = req1_d_i;
        pad_inpt_vld_o = req1_vld_i;
        pad_inpt_lst_o = req1_lst_i;
        req1_rdy_o     = pad_inpt_rdy_i;
        if (req1_vld_i && pad_inpt_rdy_i && req1_lst_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Push never coincides with full, so the count cannot overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idq_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        idq_q[wptr_q] <= gnt_id;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      if (pop) rptr_q <= rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign expnd_otpt_id_o = empty ? 1'b0 : idq_q[rptr_q];
  assign busy_o          = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_sm3_expnd_arb.sv
// tb/tb_sm3_expnd_arb.sv - directed vector bench for sm3_expnd_arb
module tb_sm3_expnd_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] r0_d, r1_d, pad_d;
  logic        r0_vld, r0_lst, r0_rdy, r1_vld, r1_lst, r1_rdy;
  logic        pad_vld, pad_lst, pad_rdy;
  logic        ev, el, ee, id, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm3_expnd_arb #(.DW(32), .IDQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_d_i(r0_d), .req0_vld_i(r0_vld), .req0_lst_i(r0_lst), .req0_rdy_o(r0_rdy),
    .req1_d_i(r1_d), .req1_vld_i(r1_vld), .req1_lst_i(r1_lst), .req1_rdy_o(r1_rdy),
    .pad_inpt_d_o(pad_d), .pad_inpt_vld_o(pad_vld), .pad_inpt_lst_o(pad_lst),
    .pad_inpt_rdy_i(pad_rdy),
    .expnd_otpt_vld_i(ev), .expnd_otpt_lst_i(el), .expnd_otpt_ena_i(ee),
    .expnd_otpt_id_o(id), .busy_o(busy)
  );

  // ctl = {r0_vld, r0_lst, r1_vld, r1_lst, pad_rdy, pop}
  // exp = {pad_vld, pad_lst, r0_rdy, r1_rdy, id, busy}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] r0d;
    logic [31:0] r1d;
    logic [5:0]  exp;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    r0_d = '0; r0_vld = 1'b0; r0_lst = 1'b0;
    r1_d = '0; r1_vld = 1'b0; r1_lst = 1'b0;
    pad_rdy = 1'b0; ev = 1'b0; el = 1'b0; ee = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pop_once();
    @(negedge clk);
    {ev, el, ee} = 3'b111;
    @(posedge clk);
    #1;
    {ev, el, ee} = 3'b000;
  endtask

  task automatic send_msg(input int req, input int n, input int stall_at, input int stall_len,
                          input logic [31:0] base, input bit pop0);
    int idx, stalls, cyc;
    idx = 0; stalls = 0; cyc = 0;
    while (idx < n && cyc < 100) begin
      @(negedge clk);
      if (req == 0) begin
        r0_vld = 1'b1; r0_d = base + 32'(idx); r0_lst = (idx == n - 1); r1_vld = 1'b0;
      end else begin
        r1_vld = 1'b1; r1_d = base + 32'(idx); r1_lst = (idx == n - 1); r0_vld = 1'b0;
      end
      pad_rdy = !(idx == stall_at && stalls < stall_len);
      {ev, el, ee} = (pop0 && cyc == 0) ? 3'b111 : 3'b000;
      #1;
      if (cyc == 0) begin
        chk("grant_latency_vld", pad_vld, 0);
      end else begin
        chk("beat_vld", pad_vld, 1);
        chk("beat_d", pad_d, base + 32'(idx));
        chk("beat_lst", pad_lst, idx == n - 1);
        chk("req_rdy", (req == 0) ? r0_rdy : r1_rdy, pad_rdy);
        chk("other_rdy", (req == 0) ? r1_rdy : r0_rdy, 0);
        if (pad_rdy) idx++;
        else stalls++;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    clear_inputs();
    chk("msg_beats", idx, n);
    chk("msg_stalls", stalls, stall_len);
  endtask

  initial begin
    tbl[0]  = '{6'b101010, 32'hA0, 32'hB0, 6'b000000, 32'h0};
    tbl[1]  = '{6'b101010, 32'hA0, 32'hB0, 6'b101001, 32'hA0};
    tbl[2]  = '{6'b111010, 32'hA1, 32'hB0, 6'b111001, 32'hA1};
    tbl[3]  = '{6'b101010, 32'hA2, 32'hB0, 6'b000001, 32'h0};
    tbl[4]  = '{6'b101011, 32'hA2, 32'hB0, 6'b100101, 32'hB0};
    tbl[5]  = '{6'b101100, 32'hA2, 32'hB1, 6'b110011, 32'hB1};
    tbl[6]  = '{6'b101110, 32'hA2, 32'hB1, 6'b110111, 32'hB1};
    tbl[7]  = '{6'b000011, 32'h0,  32'h0,  6'b000011, 32'h0};
    tbl[8]  = '{6'b000011, 32'h0,  32'h0,  6'b000000, 32'h0};
    tbl[9]  = '{6'b100010, 32'hA3, 32'h0,  6'b000000, 32'h0};
    tbl[10] = '{6'b110010, 32'hA3, 32'h0,  6'b111001, 32'hA3};
    tbl[11] = '{6'b000011, 32'h0,  32'h0,  6'b000001, 32'h0};
    tbl[12] = '{6'b000000, 32'h0,  32'h0,  6'b000000, 32'h0};

    clear_inputs();
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_id", id, 0);
    chk("rst_pad_vld", pad_vld, 0);
    chk("rst_pad_d", pad_d, 0);
    chk("rst_rdy", {r0_rdy, r1_rdy}, 0);

    // tie after reset, bubble, round-robin tie, stall, pops, empty pop
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      {r0_vld, r0_lst, r1_vld, r1_lst, pad_rdy} = tbl[i].ctl[5:1];
      {ev, el, ee} = {3{tbl[i].ctl[0]}};
      r0_d = tbl[i].r0d;
      r1_d = tbl[i].r1d;
      #1;
      chk($sformatf("tbl%0d_vld", i), pad_vld, tbl[i].exp[5]);
      chk($sformatf("tbl%0d_lst", i), pad_lst, tbl[i].exp[4]);
      chk($sformatf("tbl%0d_d", i), pad_d, tbl[i].ed);
      chk($sformatf("tbl%0d_r0rdy", i), r0_rdy, tbl[i].exp[3]);
      chk($sformatf("tbl%0d_r1rdy", i), r1_rdy, tbl[i].exp[2]);
      chk($sformatf("tbl%0d_id", i), id, tbl[i].exp[1]);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp[0]);
    end
    clear_inputs();

    // 16-word message, then expand lst handshake empties the queue
    do_reset();
    send_msg(0, 16, -1, 0, 32'h1000, 1'b0);
    @(negedge clk); #1;
    chk("m16_busy_queued", busy, 1);
    chk("m16_id", id, 0);
    pop_once();
    @(negedge clk); #1;
    chk("m16_busy_after_pop", busy, 0);

    // 3-cycle stall at beat 5
    send_msg(0, 8, 4, 3, 32'h2000, 1'b0);
    pop_once();

    // queue full blocks a fifth grant until one pop
    do_reset();
    send_msg(0, 2, -1, 0, 32'h100, 1'b0);
    send_msg(1, 2, -1, 0, 32'h200, 1'b0);
    send_msg(0, 2, -1, 0, 32'h300, 1'b0);
    send_msg(1, 2, -1, 0, 32'h400, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      r0_vld = 1'b1; r0_d = 32'h500; r0_lst = 1'b0; pad_rdy = 1'b1;
      #1;
      chk("full_no_grant_vld", pad_vld, 0);
      chk("full_no_grant_rdy", r0_rdy, 0);
      chk("full_busy", busy, 1);
    end
    @(negedge clk);
    {ev, el, ee} = 3'b111;
    #1;
    chk("full_pop_cycle_vld", pad_vld, 0);
    chk("full_pop_head", id, 0);
    @(negedge clk);
    {ev, el, ee} = 3'b000;
    #1;
    chk("full_idle_after_pop", pad_vld, 0);
    chk("full_new_head", id, 1);
    @(negedge clk);
    r0_lst = 1'b1;
    #1;
    chk("full_grant_vld", pad_vld, 1);
    chk("full_grant_rdy", r0_rdy, 1);
    chk("full_grant_d", pad_d, 32'h500);
    @(posedge clk); #1;
    clear_inputs();

    // push and pop in the same cycle at count 2
    do_reset();
    send_msg(1, 2, -1, 0, 32'h600, 1'b0);
    send_msg(0, 2, -1, 0, 32'h700, 1'b0);
    @(negedge clk); #1;
    chk("pp_head_before", id, 1);
    send_msg(1, 2, -1, 0, 32'h800, 1'b1);
    @(negedge clk); #1;
    chk("pp_head_advanced", id, 0);
    chk("pp_busy", busy, 1);
    pop_once();
    @(negedge clk); #1;
    chk("pp_tail_id", id, 1);
    chk("pp_busy2", busy, 1);
    pop_once();
    @(negedge clk); #1;
    chk("pp_empty_busy", busy, 0);
    chk("pp_empty_id", id, 0);

    // reset at beat 7 abandons the message
    do_reset();
    begin
      int idx;
      idx = 0;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        r0_vld = 1'b1; r0_d = 32'h3000 + 32'(idx); r0_lst = 1'b0;
        r1_vld = 1'b1; r1_d = 32'h4000; r1_lst = 1'b0; pad_rdy = 1'b1;
        #1;
        if (pad_vld) idx++;
      end
      chk("rst_mid_beats_before", idx, 6);
      @(negedge clk);
      r0_d = 32'h3000 + 32'(idx);
      #1;
      chk("rst_mid_beat7_vld", pad_vld, 1);
      chk("rst_mid_beat7_d", pad_d, 32'h3006);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_pad_vld", pad_vld, 0);
      chk("rst_mid_pad_d", pad_d, 0);
      chk("rst_mid_pad_lst", pad_lst, 0);
      chk("rst_mid_rdy", {r0_rdy, r1_rdy}, 0);
      chk("rst_mid_id_busy", {id, busy}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_idle_vld", pad_vld, 0);
      chk("rst_rel_busy", busy, 0);
      @(negedge clk); #1;
      chk("rst_rel_prio_rdy0", r0_rdy, 1);
      chk("rst_rel_prio_rdy1", r1_rdy, 0);
      chk("rst_rel_prio_d", pad_d, 32'h3006);
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
